// File: rtl/timer_stopwatch100hz.sv
// 100 Hz elapsed-time counter with an 8-bit register port.
// A CNTL read latches the high byte into snap so the 16-bit value reads atomically.
module timer_stopwatch100hz #(
  parameter int unsigned MCLKFREQ = 24000000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] addr,
  input  logic       rden,
  input  logic       wren,
  input  logic [7:0] di,
  output logic [7:0] q,
  output logic       tick
);

  localparam int unsigned PERIOD = MCLKFREQ / 100;
  localparam logic [17:0] RELOAD = 18'(PERIOD - 1);

  logic [17:0] prescaler;
  logic [15:0] count;
  logic [7:0]  snap;
  logic        run;
  logic        ovf;

  logic expire;
  logic stat_wr;
  logic run_start;
  logic inc;
  logic wrap;
  logic unused_di;

  assign expire    = (prescaler == '0);
  assign stat_wr   = wren && (addr == 2'd2);
  assign run_start = stat_wr && di[7] && !run;
  assign inc       = expire && run;
  assign wrap      = inc && (count == 16'hFFFF);
  assign unused_di = ^di[5:1];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      prescaler <= RELOAD;
      count     <= '0;
      snap      <= '0;
      run       <= 1'b0;
      ovf       <= 1'b0;
      q         <= '0;
      tick      <= 1'b0;
    end else begin
      tick <= expire;

      // Starting the counter realigns the prescaler so the first increment is a full period away.
      if (expire || run_start)
        prescaler <= RELOAD;
      else
        prescaler <= prescaler - 18'd1;

      if (stat_wr && di[0])
        count <= '0;
      else if (inc)
        count <= count + 16'd1;

      if (wrap)
        ovf <= 1'b1;
      else if (stat_wr && di[6])
        ovf <= 1'b0;

      if (stat_wr)
        run <= di[7];

      if (rden) begin
        unique case (addr)
          2'd0: begin
            q    <= count[7:0];
            snap <= count[15:8];
          end
          2'd1:    q <= snap;
          2'd2:    q <= {run, ovf, 6'b0};
          default: q <= '0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_timer_stopwatch100hz.sv
// Directed bench for timer_stopwatch100hz at MCLKFREQ=1000 (10-clock tick period).
module tb_timer_stopwatch100hz;

  logic       clk;
  logic       reset_n;
  logic [1:0] addr;
  logic       rden;
  logic       wren;
  logic [7:0] di;
  logic [7:0] q;
  logic       tick;

  int total;
  int bad;
  int ticks;

  timer_stopwatch100hz #(.MCLKFREQ(1000)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .addr   (addr),
    .rden   (rden),
    .wren   (wren),
    .di     (di),
    .q      (q),
    .tick   (tick)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [1:0] a);
    addr = a;
    rden = 1'b1;
    step();
    rden = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    addr = a;
    di   = d;
    wren = 1'b1;
    step();
    wren = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance until the cycle just after the next tick pulse, with a bounded budget.
  task automatic sync_tick;
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!tick && n < 25);
    total++;
    assert (tick === 1'b1) else begin
      bad++;
      $error("FAIL sync_tick observed=%0b expected=1 after %0d clk", tick, n);
    end
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    reset_n = 1'b0;
    addr    = 2'd0;
    rden    = 1'b0;
    wren    = 1'b0;
    di      = 8'h00;

    // Reset and first tick
    repeat (3) step();
    chk("reset_q", q, 8'h00);
    chk("reset_tick", tick, 1'b0);
    reset_n = 1'b1;
    repeat (9) step();
    chk("tick_not_yet", tick, 1'b0);
    step();
    chk("tick_first", tick, 1'b1);
    rd(2'd2);
    chk("reset_stat", q, 8'h00);
    rd(2'd0);
    chk("reset_cntl", q, 8'h00);

    // Run/count: first increment exactly 10 clk after the run write
    wr(2'd2, 8'h80);
    repeat (9) step();
    rd(2'd0);
    chk("pre_first_inc", q, 8'h00);
    chk("tick_after_run", tick, 1'b1);
    rd(2'd0);
    chk("first_inc", q, 8'h01);
    repeat (24) step();
    rd(2'd0);
    chk("run35_cntl", q, 8'h03);
    rd(2'd1);
    chk("run35_cnth", q, 8'h00);

    // Atomic read across the 0x00FF -> 0x0100 carry
    sync_tick();
    repeat (251) sync_tick();
    repeat (9) step();
    rd(2'd0);
    chk("carry_cntl", q, 8'hFF);
    rd(2'd1);
    chk("carry_cnth", q, 8'h00);
    rd(2'd0);
    chk("post_carry_cntl", q, 8'h00);
    rd(2'd1);
    chk("post_carry_cnth", q, 8'h01);

    // Wrap: count preset just below wrap to stay within the cycle budget
    sync_tick();
    force dut.count = 16'hFFFF;
    #1 release dut.count;
    sync_tick();
    rd(2'd2);
    chk("wrap_stat", q, 8'hC0);
    rd(2'd0);
    chk("wrap_cntl", q, 8'h00);
    rd(2'd1);
    chk("wrap_cnth", q, 8'h00);

    // Wrap set beats write clear in the same cycle
    sync_tick();
    force dut.count = 16'hFFFF;
    #1 release dut.count;
    repeat (9) step();
    wr(2'd2, 8'hC0);
    rd(2'd2);
    chk("ovf_wrap_beats_clear", q, 8'hC0);
    rd(2'd0);
    chk("wrap2_cntl", q, 8'h00);
    wr(2'd2, 8'hC0);
    rd(2'd2);
    chk("ovf_cleared", q, 8'h80);

    // Clear beats tick increment at count 5
    sync_tick();
    repeat (4) sync_tick();
    repeat (9) step();
    wr(2'd2, 8'h81);
    rd(2'd0);
    chk("clear_vs_tick_cntl", q, 8'h00);
    rd(2'd1);
    chk("clear_vs_tick_cnth", q, 8'h00);

    // Freeze: count holds at 2, tick keeps pulsing
    sync_tick();
    sync_tick();
    wr(2'd2, 8'h00);
    ticks = 0;
    repeat (50) begin
      step();
      if (tick) ticks++;
    end
    chk("freeze_ticks", ticks, 32'd5);
    rd(2'd0);
    chk("freeze_cntl", q, 8'h02);
    rd(2'd2);
    chk("freeze_stat", q, 8'h00);

    // Resume, then reset mid-count
    wr(2'd2, 8'h80);
    repeat (25) step();
    rd(2'd0);
    chk("resume_cntl", q, 8'h04);
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    chk("midreset_q", q, 8'h00);
    chk("midreset_tick", tick, 1'b0);
    rd(2'd2);
    chk("midreset_stat", q, 8'h00);
    rd(2'd0);
    chk("midreset_cntl", q, 8'h00);
    rd(2'd1);
    chk("midreset_cnth", q, 8'h00);
    repeat (6) step();
    chk("midreset_tick_wait", tick, 1'b0);
    step();
    chk("midreset_tick_full", tick, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
